// File: rtl/chan_scan_mux_pkg.sv
// rtl/chan_scan_mux_pkg.sv - mode encodings and FSM state type for the channel scan mux
package chan_scan_mux_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT  = 2'b00,
    MODE_SCAN    = 2'b01,
    MODE_HOLD    = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_DIRECT = 3'd0,
    ST_SCAN   = 3'd1,
    ST_HOLD   = 3'd2,
    ST_SHOT   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/chan_scan_mux_if.sv
// rtl/chan_scan_mux_if.sv - data, control and observation signals of the channel scan mux
interface chan_scan_mux_if #(
  parameter int W  = 1,
  parameter int N  = 4,
  parameter int DW = 8
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N*W-1:0] din;
  logic [SW-1:0]  sel;
  logic [1:0]     mode;
  logic [DW-1:0]  dwell;
  logic           en;
  logic [W-1:0]   dout;
  logic           dout_valid;
  logic [SW-1:0]  cur_ch;
  logic           wrap;
  logic           done;

  modport master (
    output din, sel, mode, dwell, en,
    input  dout, dout_valid, cur_ch, wrap, done
  );

  modport slave (
    input  din, sel, mode, dwell, en,
    output dout, dout_valid, cur_ch, wrap, done
  );
endinterface

// File: rtl/chan_scan_mux_step_ctr.sv
// rtl/chan_scan_mux_step_ctr.sv - dwell counter and wrapping/saturating channel incrementer
module scan_step_ctr #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int SW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          count_i,
  input  logic          clear_i,
  input  logic          wrap_en_i,
  input  logic [DW-1:0] dwell_i,
  input  logic [SW-1:0] cur_ch_i,
  output logic          step_o,
  output logic          wrap_o,
  output logic          last_o,
  output logic [SW-1:0] next_ch_o
);
  localparam logic [SW-1:0] LAST_CH = SW'(N - 1);

  logic [DW-1:0] cnt_q;

  // >= so that shrinking dwell below the running count steps on the next cycle
  assign step_o = (cnt_q >= dwell_i);
  assign last_o = (cur_ch_i == LAST_CH);
  assign wrap_o = step_o && last_o && wrap_en_i;

  always_comb begin
    next_ch_o = cur_ch_i + SW'(1);
    if (last_o) begin
      next_ch_o = wrap_en_i ? '0 : cur_ch_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (count_i) begin
      cnt_q <= step_o ? '0 : cnt_q + DW'(1);
    end
  end
endmodule

// File: rtl/chan_scan_mux.sv
// rtl/chan_scan_mux.sv - registered N-channel selector with direct, scan, hold and one-shot sweep modes
module chan_scan_mux
  import chan_scan_mux_pkg::*;
#(
  parameter int W  = 1,
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  chan_scan_mux_if.slave  bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam logic [SW-1:0] LAST_CH = SW'(N - 1);

  state_e        state_q, state_d;
  logic [SW-1:0] cur_q, cur_d;
  logic [W-1:0]  dout_q;
  logic          valid_q;
  logic          done_q, done_d;
  logic          wrap_q, wrap_d;
  logic          hold_dout;
  logic          ctr_clear, ctr_count;
  logic          ctr_step, ctr_wrap, ctr_last;
  logic [SW-1:0] ctr_next;
  logic          wrap_en;
  logic [SW-1:0] sel_cl;
  mode_e         mode_w;
  logic [W-1:0]  ch [N];

  for (genvar k = 0; k < N; k++) begin : g_ch
    assign ch[k] = bus.din[k*W +: W];
  end

  assign mode_w  = mode_e'(bus.mode);
  assign wrap_en = (mode_w != MODE_ONESHOT);
  // extra bit keeps the clamp compare meaningful when N is a power of two
  assign sel_cl  = ({1'b0, bus.sel} > (SW+1)'(N - 1)) ? LAST_CH : bus.sel;

  scan_step_ctr #(.N(N), .DW(DW), .SW(SW)) u_step (
    .clk       (clk),
    .rst       (rst),
    .count_i   (ctr_count),
    .clear_i   (ctr_clear),
    .wrap_en_i (wrap_en),
    .dwell_i   (bus.dwell),
    .cur_ch_i  (cur_q),
    .step_o    (ctr_step),
    .wrap_o    (ctr_wrap),
    .last_o    (ctr_last),
    .next_ch_o (ctr_next)
  );

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    done_d    = done_q;
    wrap_d    = 1'b0;
    hold_dout = 1'b0;
    ctr_clear = 1'b0;
    ctr_count = 1'b0;
    if (bus.en) begin
      case (mode_w)
        MODE_DIRECT: begin
          state_d   = ST_DIRECT;
          cur_d     = sel_cl;
          done_d    = 1'b0;
          ctr_clear = 1'b1;
        end
        MODE_SCAN: begin
          state_d = ST_SCAN;
          done_d  = 1'b0;
          if (state_q != ST_SCAN) begin
            ctr_clear = 1'b1;
          end else begin
            ctr_count = 1'b1;
            wrap_d    = ctr_wrap;
            if (ctr_step) cur_d = ctr_next;
          end
        end
        MODE_HOLD: begin
          state_d   = ST_HOLD;
          done_d    = 1'b0;
          hold_dout = 1'b1;
        end
        default: begin
          if (state_q == ST_SHOT) begin
            ctr_count = 1'b1;
            if (ctr_step) begin
              if (ctr_last) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else begin
                cur_d = ctr_next;
              end
            end
          end else if (state_q != ST_DONE) begin
            // sweep always restarts from channel 0 on entry
            state_d   = ST_SHOT;
            cur_d     = '0;
            done_d    = 1'b0;
            ctr_clear = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_DIRECT;
      cur_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (bus.en) begin
      state_q <= state_d;
      cur_q   <= cur_d;
      if (!hold_dout) dout_q <= ch[cur_d];
      valid_q <= 1'b1;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end else begin
      wrap_q  <= 1'b0;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.cur_ch     = cur_q;
  assign bus.wrap       = wrap_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_chan_scan_mux.sv
// tb/tb_chan_scan_mux.sv - directed vector bench for chan_scan_mux (N=4/W=2 plus an N=3 clamp build)
module tb_chan_scan_mux;
  import chan_scan_mux_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  chan_scan_mux_if #(.W(2), .N(4), .DW(8)) bus ();
  chan_scan_mux_if #(.W(2), .N(3), .DW(8)) bus3 ();

  chan_scan_mux #(.W(2), .N(4), .DW(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
  chan_scan_mux #(.W(2), .N(3), .DW(8)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  localparam logic [7:0] DIN_STD = 8'b11_10_01_00;

  typedef struct {
    logic [1:0] mode;
    logic [1:0] sel;
    logic [7:0] dwell;
    logic [1:0] exp_cur;
    logic       exp_wrap;
    logic       exp_done;
  } vec_t;

  vec_t vecs [33];

  function automatic vec_t mk(input logic [1:0] m, input logic [1:0] s, input logic [7:0] d,
                              input logic [1:0] c, input logic w, input logic dn);
    vec_t v;
    v.mode = m; v.sel = s; v.dwell = d; v.exp_cur = c; v.exp_wrap = w; v.exp_done = dn;
    return v;
  endfunction

  function automatic logic [1:0] slice(input logic [7:0] d, input logic [1:0] c);
    return d[c*2 +: 2];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vecs[0]  = mk(2'd0, 2'd1, 8'd0, 2'd1, 1'b0, 1'b0);
    vecs[1]  = mk(2'd0, 2'd0, 8'd0, 2'd0, 1'b0, 1'b0);
    vecs[2]  = mk(2'd1, 2'd0, 8'd1, 2'd0, 1'b0, 1'b0);
    vecs[3]  = mk(2'd1, 2'd0, 8'd1, 2'd0, 1'b0, 1'b0);
    vecs[4]  = mk(2'd1, 2'd0, 8'd1, 2'd1, 1'b0, 1'b0);
    vecs[5]  = mk(2'd1, 2'd0, 8'd1, 2'd1, 1'b0, 1'b0);
    vecs[6]  = mk(2'd1, 2'd0, 8'd1, 2'd2, 1'b0, 1'b0);
    vecs[7]  = mk(2'd1, 2'd0, 8'd1, 2'd2, 1'b0, 1'b0);
    vecs[8]  = mk(2'd1, 2'd0, 8'd1, 2'd3, 1'b0, 1'b0);
    vecs[9]  = mk(2'd1, 2'd0, 8'd1, 2'd3, 1'b0, 1'b0);
    vecs[10] = mk(2'd1, 2'd0, 8'd1, 2'd0, 1'b1, 1'b0);
    vecs[11] = mk(2'd1, 2'd0, 8'd1, 2'd0, 1'b0, 1'b0);
    vecs[12] = mk(2'd1, 2'd0, 8'd1, 2'd1, 1'b0, 1'b0);
    vecs[13] = mk(2'd1, 2'd0, 8'd0, 2'd2, 1'b0, 1'b0);
    vecs[14] = mk(2'd1, 2'd0, 8'd0, 2'd3, 1'b0, 1'b0);
    vecs[15] = mk(2'd1, 2'd0, 8'd0, 2'd0, 1'b1, 1'b0);
    vecs[16] = mk(2'd1, 2'd0, 8'd0, 2'd1, 1'b0, 1'b0);
    vecs[17] = mk(2'd0, 2'd3, 8'd0, 2'd3, 1'b0, 1'b0);
    vecs[18] = mk(2'd3, 2'd0, 8'd2, 2'd0, 1'b0, 1'b0);
    for (int i = 19; i <= 20; i++) vecs[i] = mk(2'd3, 2'd0, 8'd2, 2'd0, 1'b0, 1'b0);
    for (int i = 21; i <= 23; i++) vecs[i] = mk(2'd3, 2'd0, 8'd2, 2'd1, 1'b0, 1'b0);
    for (int i = 24; i <= 26; i++) vecs[i] = mk(2'd3, 2'd0, 8'd2, 2'd2, 1'b0, 1'b0);
    for (int i = 27; i <= 29; i++) vecs[i] = mk(2'd3, 2'd0, 8'd2, 2'd3, 1'b0, 1'b0);
    vecs[30] = mk(2'd3, 2'd0, 8'd2, 2'd3, 1'b0, 1'b1);
    vecs[31] = mk(2'd3, 2'd0, 8'd2, 2'd3, 1'b0, 1'b1);
    vecs[32] = mk(2'd0, 2'd1, 8'd2, 2'd1, 1'b0, 1'b0);

    bus.din = DIN_STD; bus.sel = 2'd0; bus.mode = MODE_DIRECT; bus.dwell = 8'd0; bus.en = 1'b0;
    bus3.din = 6'b11_01_10; bus3.sel = 2'd0; bus3.mode = MODE_DIRECT; bus3.dwell = 8'd0; bus3.en = 1'b0;

    // reset values, then async reset in the middle of a scan
    #1;
    chk("rst_dout", bus.dout, 0);
    chk("rst_valid", bus.dout_valid, 0);
    chk("rst_cur", bus.cur_ch, 0);
    step(2);
    rst = 1'b0;
    bus.en = 1'b1; bus.mode = MODE_SCAN; bus.dwell = 8'd0;
    step(2);
    chk("pre_rst_cur", bus.cur_ch, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_cur", bus.cur_ch, 0);
    chk("async_rst_dout", bus.dout, 0);
    chk("async_rst_valid", bus.dout_valid, 0);
    chk("async_rst_wrap_done", {bus.wrap, bus.done}, 0);
    rst = 1'b0;
    bus.en = 1'b0;
    step(1);
    chk("en0_valid", bus.dout_valid, 0);
    bus.en = 1'b1; bus.mode = MODE_DIRECT; bus.sel = 2'd2;
    step(1);
    chk("post_rst_cur", bus.cur_ch, 2);
    chk("post_rst_dout", bus.dout, 2'b10);
    chk("post_rst_valid", bus.dout_valid, 1);

    for (int i = 0; i < 33; i++) begin
      bus.mode = vecs[i].mode; bus.sel = vecs[i].sel; bus.dwell = vecs[i].dwell;
      step(1);
      chk($sformatf("vec%0d_cur", i), bus.cur_ch, vecs[i].exp_cur);
      chk($sformatf("vec%0d_dout", i), bus.dout, slice(DIN_STD, vecs[i].exp_cur));
      chk($sformatf("vec%0d_wrap", i), bus.wrap, vecs[i].exp_wrap);
      chk($sformatf("vec%0d_done", i), bus.done, vecs[i].exp_done);
    end

    // HOLD freezes dout while din changes
    bus.mode = MODE_SCAN; bus.dwell = 8'd0;
    step(2);
    chk("scan_pre_hold_cur", bus.cur_ch, 2);
    bus.mode = MODE_HOLD;
    step(1);
    chk("hold_dout0", bus.dout, 2'b10);
    bus.din = 8'h1B;
    step(1);
    chk("hold_dout1", bus.dout, 2'b10);
    bus.din = 8'h55;
    step(1);
    chk("hold_dout2", bus.dout, 2'b10);
    chk("hold_cur", bus.cur_ch, 2);
    bus.din = DIN_STD;

    // en=0 mid-dwell: counter resumes where it stopped
    bus.mode = MODE_SCAN; bus.dwell = 8'd3;
    step(3);
    chk("dwell_mid_cur", bus.cur_ch, 2);
    bus.en = 1'b0;
    step(5);
    chk("en0_cur", bus.cur_ch, 2);
    bus.en = 1'b1;
    step(1);
    chk("resume_cur0", bus.cur_ch, 2);
    step(1);
    chk("resume_cur1", bus.cur_ch, 3);
    bus.dwell = 8'd0;
    step(1);
    chk("wrap_pulse", bus.wrap, 1);
    chk("wrap_cur", bus.cur_ch, 0);
    bus.en = 1'b0;
    step(1);
    chk("en0_wrap_low", bus.wrap, 0);
    chk("en0_wrap_cur", bus.cur_ch, 0);

    // shrinking dwell below the running count steps on the next cycle
    bus.en = 1'b1; bus.dwell = 8'd5;
    step(3);
    chk("long_dwell_cur", bus.cur_ch, 0);
    bus.dwell = 8'd1;
    step(1);
    chk("shrink_step_cur", bus.cur_ch, 1);
    step(1);
    chk("shrink_hold_cur", bus.cur_ch, 1);
    step(1);
    chk("shrink_next_cur", bus.cur_ch, 2);

    // N=3 build clamps sel=3 to channel 2
    bus3.en = 1'b1; bus3.mode = MODE_DIRECT; bus3.sel = 2'd3;
    step(1);
    chk("clamp_cur", bus3.cur_ch, 2);
    chk("clamp_dout", bus3.dout, 2'b11);
    bus3.sel = 2'd1;
    step(1);
    chk("n3_sel1_dout", bus3.dout, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
